// File: rtl/prog_mealy_fsm.sv
// prog_mealy_fsm -- run-time programmable Mealy FSM engine.
//
// Each state owns N_RULES priority-ordered (mask, value) input matches. The
// lowest-indexed valid matching rule of the current state drives y/hit and
// selects the next state. The rule table is loaded through the cfg_* port.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en            step enable (gates y/hit and the state transition)
//   x             FSM inputs (x[0] = benchmark x1)
//   y, hit        combinational Mealy output word / rule-matched flag
//   state_o       registered current state index
//   cfg_we        table write strobe; cfg_addr = {state, rule}
//   cfg_data      {valid, mask, value, next, out}
//   key           lock key (only with FSM_KEY_LOCK_EN)
//
// Build option: define FSM_KEY_LOCK_EN to add the key port. A wrong key
// inverts y on a hit and advances the selected next state by one (mod N_STATES).

// One rule comparator; the top instantiates an array of these, one per rule.
module prog_mealy_fsm_rule #(
  parameter int N_IN = 7
) (
  input  logic            valid,
  input  logic [N_IN-1:0] mask,
  input  logic [N_IN-1:0] value,
  input  logic [N_IN-1:0] x,
  output logic            match
);
  assign match = valid && ((x & mask) == (value & mask));
endmodule

module prog_mealy_fsm #(
  parameter int                N_IN      = 7,
  parameter int                N_OUT     = 9,
  parameter int                N_STATES  = 9,
  parameter int                N_RULES   = 6,
  parameter int                KEY_W     = 16,
  parameter logic [KEY_W-1:0]  KEY_VALUE = 16'hA5C3,
  localparam int               SW        = $clog2(N_STATES),
  localparam int               RW        = $clog2(N_RULES),
  localparam int               CW        = 1 + 2*N_IN + SW + N_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  x,
  output logic [N_OUT-1:0] y,
  output logic [SW-1:0]    state_o,
  output logic             hit,
  input  logic             cfg_we,
  input  logic [SW+RW-1:0] cfg_addr,
  input  logic [CW-1:0]    cfg_data
`ifdef FSM_KEY_LOCK_EN
  ,
  input  logic [KEY_W-1:0] key
`endif
);

  typedef struct packed {
    logic             valid;
    logic [N_IN-1:0]  mask;
    logic [N_IN-1:0]  value;
    logic [SW-1:0]    nxt;
    logic [N_OUT-1:0] out;
  } rule_t;

  localparam logic [SW-1:0] LAST_ST = SW'(N_STATES - 1);
  localparam logic [RW-1:0] LAST_RL = RW'(N_RULES - 1);

  logic [SW-1:0] state_q, state_d;
  rule_t         tbl_q [N_STATES][N_RULES];
  rule_t         tbl_d [N_STATES][N_RULES];

  // ---- table write port ----
  logic [SW-1:0] cfg_st;
  logic [RW-1:0] cfg_rl;
  assign cfg_st = cfg_addr[SW+RW-1:RW];
  assign cfg_rl = cfg_addr[RW-1:0];

  always_comb begin
    tbl_d = tbl_q;
    // Out-of-range addresses are dropped rather than aliased onto real entries.
    if (cfg_we && (cfg_st <= LAST_ST) && (cfg_rl <= LAST_RL))
      tbl_d[cfg_st][cfg_rl] = rule_t'(cfg_data);
  end

  // ---- rule match, one comparator per rule of the current state ----
  logic [N_RULES-1:0] match;

  for (genvar gr = 0; gr < N_RULES; gr++) begin : g_rule
    prog_mealy_fsm_rule #(.N_IN(N_IN)) u_rule (
      .valid (tbl_q[state_q][gr].valid),
      .mask  (tbl_q[state_q][gr].mask),
      .value (tbl_q[state_q][gr].value),
      .x     (x),
      .match (match[gr])
    );
  end

  // Descending scan so the lowest-indexed match is the last one written.
  logic [SW-1:0]    win_nxt;
  logic [N_OUT-1:0] win_out;
  always_comb begin
    win_nxt = '0;
    win_out = '0;
    for (int r = N_RULES - 1; r >= 0; r--) begin
      if (match[r]) begin
        win_nxt = tbl_q[state_q][r].nxt;
        win_out = tbl_q[state_q][r].out;
      end
    end
  end

  // ---- key gate ----
  logic [KEY_W-1:0] key_int;
`ifdef FSM_KEY_LOCK_EN
  assign key_int = key;
`else
  // Tied to the correct key so the gate folds away to "unlocked".
  assign key_int = KEY_VALUE;
`endif
  logic key_ok;
  assign key_ok = (key_int == KEY_VALUE);

  // ---- next state / outputs ----
  logic [SW-1:0]    nxt_legal, nxt_step;
  logic [N_OUT-1:0] y_win;

  always_comb begin
    // Illegal-state recovery first; the lock increment applies on top of it.
    nxt_legal = (win_nxt > LAST_ST) ? '0 : win_nxt;
    nxt_step  = nxt_legal;
    y_win     = win_out;
    if (!key_ok) begin
      y_win    = ~win_out;
      nxt_step = (nxt_legal == LAST_ST) ? '0 : nxt_legal + SW'(1);
    end

    state_d = state_q;
    y       = '0;
    hit     = 1'b0;
    if (en && (|match)) begin
      hit     = 1'b1;
      y       = y_win;
      state_d = nxt_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      for (int s = 0; s < N_STATES; s++)
        for (int r = 0; r < N_RULES; r++)
          tbl_q[s][r].valid <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
    end
  end

  assign state_o = state_q;

endmodule
